// File: rtl/dram_port_arbiter_pkg.sv
// Shared types and constants for the two-port DRAM user-port arbiter.
// Build option: DRAM_ARB_FIXED_PRIO_EN selects fixed data-port priority.
package dram_arb_pkg;

    localparam int ADDR_W_DEF = 27;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic PORT_IF   = 1'b0;
    localparam logic PORT_DATA = 1'b1;

endpackage

// File: rtl/dram_port_arbiter_if.sv
// Requester-side and DRAM-side handshake bundles for the DRAM port arbiter.
// The arbiter is the slave of each requester and the master of the DRAM port.
interface dram_req_if #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 32
);
    logic              valid;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              done;
    logic [DATA_W-1:0] rdata;

    modport master (
        output valid, rw, addr, wdata,
        input  done, rdata
    );

    modport slave (
        input  valid, rw, addr, wdata,
        output done, rdata
    );
endinterface

interface dram_mem_if #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] addr_dram;
    logic [DATA_W-1:0] din_dram;
    logic              rw_dram;
    logic              valid_dram;
    logic [DATA_W-1:0] dout_dram;
    logic              ready_dram;

    modport master (
        output addr_dram, din_dram, rw_dram, valid_dram,
        input  dout_dram, ready_dram
    );

    modport slave (
        input  addr_dram, din_dram, rw_dram, valid_dram,
        output dout_dram, ready_dram
    );
endinterface

// File: rtl/dram_port_arbiter_rr_arb2.sv
// Combinational two-way picker: returns the index of the winning requester.
// Contention goes to the port other than last, or always to data when fixed.
module rr_arb2
    import dram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed_prio,
    output logic       grant
);

    always_comb begin
        grant = PORT_IF;
        if (req == 2'b11) begin
            grant = fixed_prio ? PORT_DATA : ~last;
        end else begin
            grant = req[1];
        end
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares one DRAM user port between instruction fetch (m0) and data (m1).
// Build option: DRAM_ARB_FIXED_PRIO_EN gives port 1 fixed priority.
module dram_port_arbiter
    import dram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    dram_req_if.slave   m0,
    dram_req_if.slave   m1,
    dram_mem_if.master  dram,
    output logic        busy
);

`ifdef DRAM_ARB_FIXED_PRIO_EN
    localparam logic FIXED_PRIO = 1'b1;
`else
    localparam logic FIXED_PRIO = 1'b0;
`endif

    state_t            r_state;
    logic              r_grant;
    logic              r_last_grant;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din;
    logic              r_rw;
    logic [1:0]        r_done;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic [1:0] w_req;
    logic       w_grant;

    assign w_req = {m1.valid, m0.valid};

    rr_arb2 u_rr_arb2 (
        .req        (w_req),
        .last       (r_last_grant),
        .fixed_prio (FIXED_PRIO),
        .grant      (w_grant)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_grant      <= PORT_IF;
            r_last_grant <= PORT_IF;
            r_addr       <= '0;
            r_din        <= '0;
            r_rw         <= 1'b0;
            r_done       <= 2'b00;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
                        r_grant <= w_grant;
                        r_addr  <= w_grant ? m1.addr  : m0.addr;
                        r_din   <= w_grant ? m1.wdata : m0.wdata;
                        r_rw    <= w_grant ? m1.rw    : m0.rw;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dram.ready_dram) begin
                        // writes leave the requester's read data untouched
                        if (!r_rw && !r_grant) r_rdata0 <= dram.dout_dram;
                        if (!r_rw &&  r_grant) r_rdata1 <= dram.dout_dram;
                        r_done[r_grant] <= 1'b1;
                        r_state         <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_done       <= 2'b00;
                    r_last_grant <= r_grant;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // valid drops in the ready cycle so the controller never sees a repeat
    assign dram.valid_dram = (r_state == ST_WAIT) & ~dram.ready_dram;
    assign dram.addr_dram  = r_addr;
    assign dram.din_dram   = r_din;
    assign dram.rw_dram    = r_rw;

    assign m0.done  = r_done[0];
    assign m1.done  = r_done[1];
    assign m0.rdata = r_rdata0;
    assign m1.rdata = r_rdata1;

    assign busy = (r_state != ST_IDLE);

endmodule
